// File: rtl/wall_pkg.sv
// Shared definitions for the multi-wall controller: FSM state encoding,
// state width and a width helper for index/counter registers.
package wall_pkg;

   localparam int STATE_W = 3;

   localparam logic [2:0] ST_READY = 3'd0;
   localparam logic [2:0] ST_DRAW  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_MOVE  = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;

   // Register width able to count 0..n-1, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wall_pos_unit.sv
// One wall channel: holds the wall x position, reloads it to its start
// value, and steps it left with wrap-around at the playfield edge.
module wall_pos_unit #(
   parameter int X_W      = 8,
   parameter int SCREEN_W = 160,
   parameter int STEP     = 1,
   parameter int INIT_X   = 159
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           load,
   input  logic           step,
   output logic [X_W-1:0] x,
   output logic           wrap
);

   localparam logic [X_W-1:0] INIT_V   = X_W'(INIT_X);
   localparam logic [X_W-1:0] STEP_V   = X_W'(STEP);
   // SCREEN_W-STEP always fits in X_W bits since SCREEN_W <= 2**X_W and STEP >= 1
   localparam logic [X_W-1:0] WRAP_ADD = X_W'(SCREEN_W - STEP);

   // A step from below STEP leaves the left edge and re-enters on the right
   assign wrap = (x < STEP_V);

   // Position register: reload on reset/load, otherwise step when asked
   always_ff @(posedge clk) begin
      if (!resetn || load)
         x <= INIT_V;
      else if (step)
         x <= wrap ? (x + WRAP_ADD) : (x - STEP_V);
   end

endmodule

// File: rtl/wall_ctrl_multi.sv
// Multi-wall controller: sequences renderer requests for every wall, paces
// wall movement from frame ticks and stops on collision.
// Optional: define WALL_SCORE_EN to count walls wrapping past the left edge.
module wall_ctrl_multi
   import wall_pkg::*;
#(
   parameter int N_WALLS  = 3,
   parameter int X_W      = 8,
   parameter int SCREEN_W = 160,
   parameter int SPACING  = 54,
   parameter int TICK_DIV = 4,
   parameter int STEP     = 1,
   localparam int IDX_W   = idx_width(N_WALLS)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               go,
   input  logic               touched,
   input  logic               frame_tick,
   input  logic               draw_done,
   output logic               draw_req,
   output logic [IDX_W-1:0]   draw_idx,
   output logic [X_W-1:0]     draw_x,
   output logic               running,
   output logic               stopped,
   output logic [STATE_W-1:0] state,
   output logic [7:0]         score
);

   localparam int CNT_W = idx_width(TICK_DIV);

   logic [STATE_W-1:0]            state_q, state_d;
   logic [IDX_W-1:0]              idx_q;
   logic [CNT_W-1:0]              cnt_q;
   logic                          pend_q;
   logic [N_WALLS-1:0][X_W-1:0]   xs;
   logic [N_WALLS-1:0]            wraps;
   logic                          last_idx, cnt_last;
   logic                          in_ready, in_draw, in_run, in_move;

   assign in_ready = (state_q == ST_READY);
   assign in_draw  = (state_q == ST_DRAW);
   assign in_run   = (state_q == ST_RUN);
   assign in_move  = (state_q == ST_MOVE);
   assign last_idx = (idx_q == IDX_W'(N_WALLS - 1));
   assign cnt_last = (cnt_q == CNT_W'(TICK_DIV - 1));

   assign state    = state_q;
   assign draw_req = in_draw;
   assign running  = in_run;
   assign stopped  = (state_q == ST_STOP);
   assign draw_idx = idx_q;
   assign draw_x   = xs[idx_q];

   genvar gi;
   generate
      for (gi = 0; gi < N_WALLS; gi++) begin : g_wall
         wall_pos_unit #(
            .X_W      (X_W),
            .SCREEN_W (SCREEN_W),
            .STEP     (STEP),
            .INIT_X   (SCREEN_W - 1 - gi * SPACING)
         ) u_pos (
            .clk    (clk),
            .resetn (resetn),
            .load   (in_ready),
            .step   (in_move),
            .x      (xs[gi]),
            .wrap   (wraps[gi])
         );
      end
   endgenerate

   // Next-state logic; unused encodings fall back to READY
   always_comb begin
      state_d = ST_READY;
      case (state_q)
         ST_READY: state_d = go ? ST_DRAW : ST_READY;
         ST_DRAW:
            if (draw_done && last_idx)
               state_d = (pend_q || touched) ? ST_STOP : ST_RUN;
            else
               state_d = ST_DRAW;
         ST_RUN:
            if (touched)
               state_d = ST_STOP;
            else if (frame_tick && cnt_last)
               state_d = ST_MOVE;
            else
               state_d = ST_RUN;
         ST_MOVE: state_d = ST_DRAW;
         ST_STOP: state_d = go ? ST_STOP : ST_READY;
         default: state_d = ST_READY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_READY;
      else         state_q <= state_d;
   end

   // Draw index walks the walls, advancing after each accepted draw_done
   always_ff @(posedge clk) begin
      if (!resetn)
         idx_q <= '0;
      else if (in_draw && draw_done)
         idx_q <= last_idx ? '0 : idx_q + 1'b1;
      else if (!in_draw)
         idx_q <= '0;
   end

   // Frame tick divider; a collision in the same cycle leaves it untouched
   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else if (in_run && !touched && frame_tick)
         cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
   end

   // Collision seen while drawing is remembered until the sequence completes
   always_ff @(posedge clk) begin
      if (!resetn)
         pend_q <= 1'b0;
      else if (state_d == ST_READY)
         pend_q <= 1'b0;
      else if (in_draw && touched)
         pend_q <= 1'b1;
   end

`ifdef WALL_SCORE_EN
   logic [7:0] score_q;
   logic [3:0] nwrap;
   logic [8:0] sum;

   // Count walls wrapping in this move step
   always_comb begin
      nwrap = '0;
      for (int i = 0; i < N_WALLS; i++)
         nwrap = nwrap + 4'(wraps[i]);
      sum = {1'b0, score_q} + 9'(nwrap);
   end

   // Saturating score, cleared while waiting in READY
   always_ff @(posedge clk) begin
      if (!resetn || in_ready)
         score_q <= '0;
      else if (in_move)
         score_q <= sum[8] ? 8'hFF : sum[7:0];
   end

   assign score = score_q;
`else
   logic unused_wraps;
   assign unused_wraps = ^wraps;
   assign score = 8'd0;
`endif

endmodule

// File: tb/tb_wall_ctrl_multi.sv
// Randomized self-checking bench for wall_ctrl_multi with a transaction-level
// model of wall positions, tick pacing and score.
module tb_wall_ctrl_multi;
   import wall_pkg::*;

   localparam int N  = 3;
   localparam int XW = 8;
   localparam int SW = 160;
   localparam int SP = 54;
   localparam int TD = 4;
   localparam int ST = 1;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          go = 1'b0;
   logic          touched = 1'b0;
   logic          frame_tick = 1'b0;
   logic          draw_done = 1'b0;
   logic          draw_req;
   logic [IW-1:0] draw_idx;
   logic [XW-1:0] draw_x;
   logic          running, stopped;
   logic [2:0]    state;
   logic [7:0]    score;

   wall_ctrl_multi #(
      .N_WALLS(N), .X_W(XW), .SCREEN_W(SW), .SPACING(SP), .TICK_DIV(TD), .STEP(ST)
   ) dut (
      .clk(clk), .resetn(resetn), .go(go), .touched(touched),
      .frame_tick(frame_tick), .draw_done(draw_done), .draw_req(draw_req),
      .draw_idx(draw_idx), .draw_x(draw_x), .running(running),
      .stopped(stopped), .state(state), .score(score)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;
   int mx[N];
   int mscore;
   int cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int exp_score();
`ifdef WALL_SCORE_EN
      return mscore;
`else
      return 0;
`endif
   endfunction

   task automatic reload_model();
      for (int i = 0; i < N; i++) mx[i] = SW - 1 - i * SP;
      mscore = 0;
   endtask

   // Walls move left modulo the playfield; a wall that jumps right has wrapped
   task automatic model_move();
      for (int i = 0; i < N; i++) begin
         int old;
         old = mx[i];
         mx[i] = (mx[i] - ST + SW) % SW;
         if (mx[i] > old && mscore < 255) mscore++;
      end
   endtask

   // Serve one full draw sequence; optionally raise touched while wall t is drawn
   task automatic do_draw(input int t);
      for (int i = 0; i < N; i++) begin
         int w;
         chk("draw_req", 32'(draw_req), 1);
         chk("draw_idx", 32'(draw_idx), i);
         chk("draw_x", 32'(draw_x), mx[i]);
         w = $urandom_range(0, 2);
         if (i == t && w == 0) w = 1;
         for (int j = 0; j < w; j++) begin
            touched = (i == t && j == 0);
            @(negedge clk);
            touched = 1'b0;
            chk("draw_hold_req", 32'(draw_req), 1);
            chk("draw_hold_idx", 32'(draw_idx), i);
         end
         draw_done = 1'b1;
         @(negedge clk);
         draw_done = 1'b0;
      end
   endtask

   initial begin
      reload_model();
      cnt = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'(ST_READY));
      chk("rst_draw_req", 32'(draw_req), 0);
      chk("rst_draw_idx", 32'(draw_idx), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_stopped", 32'(stopped), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_draw_x", 32'(draw_x), SW - 1);

      resetn = 1'b1;
      @(negedge clk);
      chk("idle_no_req", 32'(draw_req), 0);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk("go_latency", 32'(draw_req), 1);
      do_draw(-1);
      chk("run_after_draw", 32'(running), 1);
      chk("run_not_stopped", 32'(stopped), 0);

      // Random tick pacing over enough moves for the last wall to wrap
      for (int m = 0; m < 60; m++) begin
         bit moved;
         moved = 1'b0;
         while (!moved) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               draw_done = 1'($urandom_range(0, 1));
               @(negedge clk);
               draw_done = 1'b0;
               chk("idle_running", 32'(running), 1);
               chk("idle_idx", 32'(draw_idx), 0);
            end
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            cnt++;
            if (cnt == TD) begin
               cnt = 0;
               moved = 1'b1;
               chk("move_state", 32'(state), 32'(ST_MOVE));
               chk("move_not_running", 32'(running), 0);
               @(negedge clk);
               model_move();
               chk("score_after_move", 32'(score), exp_score());
            end else begin
               chk("no_move_running", 32'(running), 1);
               chk("no_move_req", 32'(draw_req), 0);
            end
         end
         do_draw(-1);
         chk("rerun", 32'(running), 1);
      end

      // Collision and frame tick together on the move-causing tick
      while (cnt < TD - 1) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         cnt++;
         chk("pre_touch_running", 32'(running), 1);
      end
      touched = 1'b1;
      frame_tick = 1'b1;
      go = 1'b1;
      @(negedge clk);
      touched = 1'b0;
      frame_tick = 1'b0;
      chk("touch_stopped", 32'(stopped), 1);
      chk("touch_not_running", 32'(running), 0);
      chk("touch_frozen_x", 32'(draw_x), mx[0]);
      repeat (3) @(negedge clk);
      chk("stop_hold", 32'(stopped), 1);
      chk("stop_frozen_x", 32'(draw_x), mx[0]);
      chk("stop_score", 32'(score), exp_score());
      go = 1'b0;
      @(negedge clk);
      chk("stop_to_ready", 32'(state), 32'(ST_READY));
      chk("ready_not_stopped", 32'(stopped), 0);
      @(negedge clk);
      reload_model();
      chk("ready_reload_x", 32'(draw_x), SW - 1);
      chk("ready_score_clr", 32'(score), 0);

      // Collision during draw of wall 1: sequence completes, then STOP
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      do_draw(1);
      chk("pend_stopped", 32'(stopped), 1);
      chk("pend_not_running", 32'(running), 0);
      @(negedge clk);
      chk("pend_to_ready", 32'(state), 32'(ST_READY));
      @(negedge clk);
      chk("pend_reload_x", 32'(draw_x), SW - 1);

      // Reset while draw_req is high, with draw_done also asserted
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      draw_done = 1'b1;
      @(negedge clk);
      chk("mid_draw_idx", 32'(draw_idx), 1);
      resetn = 1'b0;
      @(negedge clk);
      draw_done = 1'b0;
      chk("rst_mid_req", 32'(draw_req), 0);
      chk("rst_mid_state", 32'(state), 32'(ST_READY));
      chk("rst_mid_score", 32'(score), 0);
      chk("rst_mid_idx", 32'(draw_idx), 0);
      resetn = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
